// File: rtl/mem_indirect_arb.sv
// mem_indirect_arb
//   Round-robin arbiter and sequencer that shares one indirect-access memory
//   register port between NREQ requesters. Each granted single-word access is
//   expanded into the register-bus sequence:
//     write: wr INDIRECT_ADDR, wr INDIRECT_DATA, wr OP=WR, wr OP=NOP
//     read : wr INDIRECT_ADDR, wr OP=RD, settle, rd RDDATA, wait valid,
//            wr OP=NOP
//   All outputs are registered. A strobe is visible during the cycle in which
//   the FSM sits in the state that owns it.
//
// Ports
//   clk_i, arst_i           clock, asynchronous active-high reset
//   req_i[NREQ]             level requests, held until done_o
//   we_i[NREQ]              1=write, 0=read, sampled at grant
//   addr_i, wdata_i         packed per-requester address / write data
//   gnt_o[NREQ]             one-hot grant for the whole transaction
//   done_o[NREQ]            one-cycle completion pulse
//   rdata_o                 last read result, held until the next read ends
//   err_o                   read timeout pulse with done_o
//   bus_wr_o, bus_rd_o      register-bus write / read strobes
//   bus_addr_o, bus_data_o  register address / write data
//   bus_rddata_i            register read data
//   bus_rddatavalid_i       register read data valid
//
// Optional feature macro: MEM_INDIRECT_ARB_TIMEOUT_EN
//   Defined  : the wait for read data is bounded by TIMEOUT cycles; on expiry
//              the op register is cleared, rdata_o is zeroed and err_o pulses.
//   Undefined: the wait is unbounded and err_o is tied to 0.
module mem_indirect_arb #(
  parameter int NREQ            = 2,
  parameter int DWIDTH          = 8,
  parameter int AWIDTH          = 4,
  parameter int INDIRECT_AWIDTH = 8,
  parameter int RD_SETTLE       = 2,
  parameter int TIMEOUT         = 15
) (
  input  logic                            clk_i,
  input  logic                            arst_i,
  input  logic [NREQ-1:0]                 req_i,
  input  logic [NREQ-1:0]                 we_i,
  input  logic [NREQ*INDIRECT_AWIDTH-1:0] addr_i,
  input  logic [NREQ*DWIDTH-1:0]          wdata_i,
  output logic [NREQ-1:0]                 gnt_o,
  output logic [NREQ-1:0]                 done_o,
  output logic [DWIDTH-1:0]               rdata_o,
  output logic                            err_o,
  output logic                            bus_wr_o,
  output logic                            bus_rd_o,
  output logic [AWIDTH-1:0]               bus_addr_o,
  output logic [DWIDTH-1:0]               bus_data_o,
  input  logic [DWIDTH-1:0]               bus_rddata_i,
  input  logic                            bus_rddatavalid_i
);

  localparam int PW  = $clog2(NREQ);
  localparam int SCW = $clog2(RD_SETTLE);

  localparam logic [AWIDTH-1:0] REG_OP     = AWIDTH'(3);
  localparam logic [AWIDTH-1:0] REG_IADDR  = AWIDTH'(4);
  localparam logic [AWIDTH-1:0] REG_IDATA  = AWIDTH'(5);
  localparam logic [AWIDTH-1:0] REG_RDDATA = AWIDTH'(6);

  localparam logic [DWIDTH-1:0] OP_NOP = DWIDTH'(2'b00);
  localparam logic [DWIDTH-1:0] OP_RD  = DWIDTH'(2'b01);
  localparam logic [DWIDTH-1:0] OP_WR  = DWIDTH'(2'b10);

  if (NREQ < 2 || NREQ > 8 || INDIRECT_AWIDTH > DWIDTH ||
      RD_SETTLE < 2 || TIMEOUT < 1) begin : g_param_check
    $error("mem_indirect_arb: parameter out of range");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_DATA, S_OPWR, S_OPRD,
    S_SETTLE, S_RD, S_WAIT, S_CLR, S_DONE
  } state_t;

  state_t              state, state_n;
  logic [PW-1:0]       ptr, ptr_n;
  logic [PW-1:0]       win;
  logic                found;
  logic                load;
  logic                cur_we, cur_we_n;
  logic [DWIDTH-1:0]   cur_wdata;
  logic [SCW-1:0]      settle_cnt, settle_n;
  logic [NREQ-1:0]     gnt_n, done_n;
  logic [DWIDTH-1:0]   rdata_n;
  logic                wr_n, rd_n;
  logic [AWIDTH-1:0]   baddr_n;
  logic [DWIDTH-1:0]   bdata_n;

`ifdef MEM_INDIRECT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt, tmo_n;
  logic          tmo_flag, tmo_flag_n;
  logic          err_n;
`endif

  // Round-robin search: first set request at or after ptr, wrapping.
  always_comb begin
    int j;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_i[j]) begin
        found = 1'b1;
        win   = PW'(j);
      end
    end
  end

  // Next state and next registered outputs. The strobe for a state is
  // computed on the transition into it so it lines up with that state.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    cur_we_n = cur_we;
    settle_n = settle_cnt;
    load     = 1'b0;
    gnt_n    = gnt_o;
    done_n   = '0;
    rdata_n  = rdata_o;
    wr_n     = 1'b0;
    rd_n     = 1'b0;
    baddr_n  = '0;
    bdata_n  = '0;
`ifdef MEM_INDIRECT_ARB_TIMEOUT_EN
    tmo_n      = tmo_cnt;
    tmo_flag_n = tmo_flag;
    err_n      = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (found) begin
          load     = 1'b1;
          gnt_n    = NREQ'(1) << win;
          ptr_n    = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
          cur_we_n = we_i[win];
          state_n  = S_ADDR;
          wr_n     = 1'b1;
          baddr_n  = REG_IADDR;
          bdata_n  = DWIDTH'(addr_i[int'(win)*INDIRECT_AWIDTH +: INDIRECT_AWIDTH]);
`ifdef MEM_INDIRECT_ARB_TIMEOUT_EN
          tmo_flag_n = 1'b0;
`endif
        end
      end
      S_ADDR: begin
        wr_n = 1'b1;
        if (cur_we) begin
          state_n = S_DATA;
          baddr_n = REG_IDATA;
          bdata_n = cur_wdata;
        end else begin
          state_n = S_OPRD;
          baddr_n = REG_OP;
          bdata_n = OP_RD;
        end
      end
      S_DATA: begin
        state_n = S_OPWR;
        wr_n    = 1'b1;
        baddr_n = REG_OP;
        bdata_n = OP_WR;
      end
      S_OPWR: begin
        state_n = S_CLR;
        wr_n    = 1'b1;
        baddr_n = REG_OP;
        bdata_n = OP_NOP;
      end
      S_OPRD: begin
        state_n  = S_SETTLE;
        settle_n = SCW'(RD_SETTLE - 1);
      end
      S_SETTLE: begin
        if (settle_cnt == '0) begin
          state_n = S_RD;
          rd_n    = 1'b1;
          baddr_n = REG_RDDATA;
        end else begin
          settle_n = settle_cnt - 1'b1;
        end
      end
      S_RD: begin
        state_n = S_WAIT;
`ifdef MEM_INDIRECT_ARB_TIMEOUT_EN
        tmo_n = '0;
`endif
      end
      S_WAIT: begin
        if (bus_rddatavalid_i) begin
          rdata_n = bus_rddata_i;
          state_n = S_CLR;
          wr_n    = 1'b1;
          baddr_n = REG_OP;
          bdata_n = OP_NOP;
        end
`ifdef MEM_INDIRECT_ARB_TIMEOUT_EN
        else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          rdata_n    = '0;
          tmo_flag_n = 1'b1;
          state_n    = S_CLR;
          wr_n       = 1'b1;
          baddr_n    = REG_OP;
          bdata_n    = OP_NOP;
        end else begin
          tmo_n = tmo_cnt + 1'b1;
        end
`endif
      end
      S_CLR: begin
        state_n = S_DONE;
      end
      S_DONE: begin
        done_n  = gnt_o;
        gnt_n   = '0;
        state_n = S_IDLE;
`ifdef MEM_INDIRECT_ARB_TIMEOUT_EN
        err_n = tmo_flag;
`endif
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Control and output register stage
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state      <= S_IDLE;
      ptr        <= '0;
      cur_we     <= 1'b0;
      settle_cnt <= '0;
      gnt_o      <= '0;
      done_o     <= '0;
      rdata_o    <= '0;
      bus_wr_o   <= 1'b0;
      bus_rd_o   <= 1'b0;
      bus_addr_o <= '0;
      bus_data_o <= '0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      cur_we     <= cur_we_n;
      settle_cnt <= settle_n;
      gnt_o      <= gnt_n;
      done_o     <= done_n;
      rdata_o    <= rdata_n;
      bus_wr_o   <= wr_n;
      bus_rd_o   <= rd_n;
      bus_addr_o <= baddr_n;
      bus_data_o <= bdata_n;
    end
  end

  // Write data captured at grant; only consumed after grant, so no reset.
  always_ff @(posedge clk_i) begin
    if (load) cur_wdata <= wdata_i[int'(win)*DWIDTH +: DWIDTH];
  end

`ifdef MEM_INDIRECT_ARB_TIMEOUT_EN
  // Read-wait timeout register stage
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      tmo_cnt  <= tmo_n;
      tmo_flag <= tmo_flag_n;
      err_o    <= err_n;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule
